// File: rtl/gat_load_ctrl.sv
// Host-to-BRAM load controller for the GAT accelerator: steers host writes onto
// NUM_CH BRAM channels, counts words per channel and sequences the core start.
module gat_load_ctrl #(
   parameter int TOP_WIDTH = 32,
   parameter int NUM_CH    = 3,
   parameter int ADDR_W    = 18,
   parameter int DATA_W    = 24,
   parameter int CNT_W     = 19,
   parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_start,
   input  logic                    abort,
   input  logic [NUM_CH*CNT_W-1:0] cfg_len,
   input  logic                    host_ena,
   input  logic                    host_wea,
   input  logic [CH_W-1:0]         host_ch,
   input  logic [ADDR_W+1:0]       host_addr,
   input  logic [TOP_WIDTH-1:0]    host_din,
   output logic [NUM_CH-1:0]       bram_we,
   output logic [ADDR_W-1:0]       bram_addr,
   output logic [DATA_W-1:0]       bram_din,
   output logic [NUM_CH-1:0]       ch_load_done,
   output logic                    core_start,
   input  logic                    core_done,
   output logic                    ctrl_busy,
   output logic                    ctrl_ready,
   output logic [2:0]              err_flags,
   output logic [TOP_WIDTH-1:0]    wr_count_dbg
);

   localparam logic [CH_W:0]        NUM_CH_L = (CH_W+1)'(NUM_CH);
   localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [TOP_WIDTH-1:0] WR_ONE   = {{(TOP_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [TOP_WIDTH-1:0] WR_MAX   = {TOP_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                         r_state;
   state_t                         w_state_nxt;
   logic [NUM_CH-1:0][CNT_W-1:0]   r_cnt;
   logic [NUM_CH-1:0][CNT_W-1:0]   r_len;
   logic [NUM_CH-1:0][CNT_W-1:0]   w_cnt_nxt;
   logic [NUM_CH-1:0][CNT_W-1:0]   w_len_in;
   logic [NUM_CH-1:0]              r_done;
   logic [NUM_CH-1:0]              w_done_nxt;
   logic [NUM_CH-1:0]              w_we_nxt;
   logic                           w_restart;
   logic                           w_try;
   logic                           w_bad_ch;
   logic                           w_misalign;
   logic                           w_ovf;
   logic                           w_accept;
   logic [2:0]                     w_err_set;
   logic [NUM_CH-1:0]              r_we;
   logic [ADDR_W-1:0]              r_addr;
   logic [DATA_W-1:0]              r_din;
   logic                           r_core_start;
   logic                           r_busy;
   logic                           r_ready;
   logic [2:0]                     r_err;
   logic [TOP_WIDTH-1:0]           r_wr_cnt;

   generate
      if (DATA_W < TOP_WIDTH) begin : g_din_unused
         logic w_unused_din;
         assign w_unused_din = ^host_din[TOP_WIDTH-1:DATA_W];
      end
   endgenerate

   // Next-state decode; abort overrides every transition.
   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = load_start ? S_LOAD : S_IDLE;
            S_LOAD:  w_state_nxt = (&r_done) ? S_START : S_LOAD;
            S_START: w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = core_done ? S_DONE : S_RUN;
            S_DONE:  w_state_nxt = load_start ? S_LOAD : S_DONE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Host write qualification with prioritised drop reasons.
   always_comb begin
      w_restart  = load_start & ~abort & ((r_state == S_IDLE) | (r_state == S_DONE));
      w_try      = (r_state == S_LOAD) & ~abort & host_ena & host_wea;
      w_bad_ch   = ({1'b0, host_ch} >= NUM_CH_L);
      w_misalign = (host_addr[1:0] != 2'b00);
      w_ovf      = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_ovf = w_ovf | ((host_ch == CH_W'(i)) & (r_cnt[i] == r_len[i]));
      end
      w_accept     = w_try & ~w_bad_ch & ~w_misalign & ~w_ovf;
      w_err_set[0] = w_try & w_bad_ch;
      w_err_set[1] = w_try & ~w_bad_ch & w_misalign;
      w_err_set[2] = w_try & ~w_bad_ch & ~w_misalign & w_ovf;
   end

   // Per-channel strobe, word count and done bit; done tracks the post-update count.
   always_comb begin
      w_we_nxt   = {NUM_CH{1'b0}};
      w_cnt_nxt  = r_cnt;
      w_done_nxt = r_done;
      w_len_in   = '{default: {CNT_W{1'b0}}};
      for (int i = 0; i < NUM_CH; i++) begin
         w_len_in[i] = cfg_len[i*CNT_W +: CNT_W];
         w_we_nxt[i] = w_accept & (host_ch == CH_W'(i));
         if (abort) begin
            w_cnt_nxt[i]  = {CNT_W{1'b0}};
            w_done_nxt[i] = 1'b0;
         end else if (w_restart) begin
            w_cnt_nxt[i]  = {CNT_W{1'b0}};
            w_done_nxt[i] = (w_len_in[i] == {CNT_W{1'b0}});
         end else if (w_we_nxt[i]) begin
            w_cnt_nxt[i]  = r_cnt[i] + CNT_ONE;
            w_done_nxt[i] = ((r_cnt[i] + CNT_ONE) == r_len[i]);
         end else begin
            w_cnt_nxt[i]  = r_cnt[i];
            w_done_nxt[i] = r_done[i];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Channel counters, done bits and lengths latched at load start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '{default: {CNT_W{1'b0}}};
         r_len  <= '{default: {CNT_W{1'b0}}};
         r_done <= {NUM_CH{1'b0}};
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_done <= w_done_nxt;
         if (w_restart) r_len <= w_len_in;
         else           r_len <= r_len;
      end
   end

   // Registered BRAM write port; address and data hold between accepted writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we   <= {NUM_CH{1'b0}};
         r_addr <= {ADDR_W{1'b0}};
         r_din  <= {DATA_W{1'b0}};
      end else begin
         r_we <= w_we_nxt;
         if (w_accept) begin
            r_addr <= host_addr[ADDR_W+1:2];
            r_din  <= host_din[DATA_W-1:0];
         end else begin
            r_addr <= r_addr;
            r_din  <= r_din;
         end
      end
   end

   // Control outputs decoded from the next state so they line up with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_core_start <= 1'b0;
         r_busy       <= 1'b0;
         r_ready      <= 1'b0;
      end else begin
         r_core_start <= (w_state_nxt == S_START);
         r_busy       <= (w_state_nxt == S_LOAD) | (w_state_nxt == S_START) |
                         (w_state_nxt == S_RUN);
         r_ready      <= (w_state_nxt == S_DONE);
      end
   end

   // Sticky error flags and saturating accepted-write counter, cleared on restart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err    <= 3'b000;
         r_wr_cnt <= {TOP_WIDTH{1'b0}};
      end else if (w_restart) begin
         r_err    <= 3'b000;
         r_wr_cnt <= {TOP_WIDTH{1'b0}};
      end else begin
         r_err <= r_err | w_err_set;
         if (w_accept && (r_wr_cnt != WR_MAX)) r_wr_cnt <= r_wr_cnt + WR_ONE;
         else                                  r_wr_cnt <= r_wr_cnt;
      end
   end

   assign bram_we      = r_we;
   assign bram_addr    = r_addr;
   assign bram_din     = r_din;
   assign ch_load_done = r_done;
   assign core_start   = r_core_start;
   assign ctrl_busy    = r_busy;
   assign ctrl_ready   = r_ready;
   assign err_flags    = r_err;
   assign wr_count_dbg = r_wr_cnt;

endmodule

// File: tb/tb_gat_load_ctrl.sv
// Directed bench for gat_load_ctrl: expected BRAM strobes are queued when a host
// write is driven and popped on the following clock edge.
module tb_gat_load_ctrl;

   logic        clk;
   logic        rst_n;
   logic        load_start;
   logic        abort;
   logic [56:0] cfg_len;
   logic        host_ena;
   logic        host_wea;
   logic [1:0]  host_ch;
   logic [19:0] host_addr;
   logic [31:0] host_din;
   logic [2:0]  bram_we;
   logic [17:0] bram_addr;
   logic [23:0] bram_din;
   logic [2:0]  ch_load_done;
   logic        core_start;
   logic        core_done;
   logic        ctrl_busy;
   logic        ctrl_ready;
   logic [2:0]  err_flags;
   logic [31:0] wr_count_dbg;

   typedef struct {
      logic [1:0]  ch;
      logic [17:0] addr;
      logic [23:0] din;
   } wr_t;

   wr_t exp_q[$];
   int  n_vec;
   int  n_err;
   int  n_cs;

   gat_load_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_start   (load_start),
      .abort        (abort),
      .cfg_len      (cfg_len),
      .host_ena     (host_ena),
      .host_wea     (host_wea),
      .host_ch      (host_ch),
      .host_addr    (host_addr),
      .host_din     (host_din),
      .bram_we      (bram_we),
      .bram_addr    (bram_addr),
      .bram_din     (bram_din),
      .ch_load_done (ch_load_done),
      .core_start   (core_start),
      .core_done    (core_done),
      .ctrl_busy    (ctrl_busy),
      .ctrl_ready   (ctrl_ready),
      .err_flags    (err_flags),
      .wr_count_dbg (wr_count_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; the strobe seen after the edge must match the write queued before it.
   task automatic cyc();
      wr_t        e;
      logic [2:0] we_exp;
      @(posedge clk);
      #1;
      we_exp = 3'b000;
      if (exp_q.size() > 0) begin
         e      = exp_q.pop_front();
         we_exp = 3'b001 << e.ch;
         chk("bram_addr", {46'd0, bram_addr}, {46'd0, e.addr});
         chk("bram_din", {40'd0, bram_din}, {40'd0, e.din});
      end
      chk("bram_we", {61'd0, bram_we}, {61'd0, we_exp});
   endtask

   task automatic wr(input logic [1:0] ch, input logic [19:0] addr,
                     input logic [31:0] din, input bit ok);
      wr_t e;
      host_ena  = 1'b1;
      host_wea  = 1'b1;
      host_ch   = ch;
      host_addr = addr;
      host_din  = din;
      if (ok) begin
         e.ch   = ch;
         e.addr = addr[19:2];
         e.din  = din[23:0];
         exp_q.push_back(e);
      end
      cyc();
      host_ena = 1'b0;
      host_wea = 1'b0;
   endtask

   task automatic start_load(input logic [18:0] l0, input logic [18:0] l1, input logic [18:0] l2);
      cfg_len    = {l2, l1, l0};
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_we"}, {61'd0, bram_we}, 64'd0);
      chk({tag, "_addr"}, {46'd0, bram_addr}, 64'd0);
      chk({tag, "_din"}, {40'd0, bram_din}, 64'd0);
      chk({tag, "_done"}, {61'd0, ch_load_done}, 64'd0);
      chk({tag, "_core_start"}, {63'd0, core_start}, 64'd0);
      chk({tag, "_busy"}, {63'd0, ctrl_busy}, 64'd0);
      chk({tag, "_ready"}, {63'd0, ctrl_ready}, 64'd0);
      chk({tag, "_err"}, {61'd0, err_flags}, 64'd0);
      chk({tag, "_wrcnt"}, {32'd0, wr_count_dbg}, 64'd0);
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      load_start = 1'b0;
      abort      = 1'b0;
      cfg_len    = 57'd0;
      host_ena   = 1'b0;
      host_wea   = 1'b0;
      host_ch    = 2'd0;
      host_addr  = 20'd0;
      host_din   = 32'd0;
      core_done  = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Reset in the middle of a load after five accepted writes.
      start_load(19'd4, 19'd2, 19'd3);
      chk("load_busy", {63'd0, ctrl_busy}, 64'd1);
      wr(2'd0, 20'h00000, 32'hFF111111, 1'b1);
      wr(2'd1, 20'h00010, 32'hFF222222, 1'b1);
      wr(2'd2, 20'h00020, 32'hFF333333, 1'b1);
      wr(2'd0, 20'h00004, 32'hFF444444, 1'b1);
      wr(2'd2, 20'h00024, 32'hFF555555, 1'b1);
      chk("mid_wrcnt", {32'd0, wr_count_dbg}, 64'd5);
      rst_n = 1'b0;
      #2;
      chk_all_zero("async_reset");
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      wr(2'd0, 20'h00000, 32'h00000001, 1'b0);
      chk("idle_wr_ignored_busy", {63'd0, ctrl_busy}, 64'd0);
      chk("idle_wr_ignored_cnt", {32'd0, wr_count_dbg}, 64'd0);

      // Full load: ch0=4, ch1=2, ch2=3 words, nine interleaved aligned writes.
      start_load(19'd4, 19'd2, 19'd3);
      chk("t2_done_start", {61'd0, ch_load_done}, 64'd0);
      wr(2'd0, 20'h00000, 32'hA5000010, 1'b1);
      wr(2'd1, 20'h00100, 32'hA5000020, 1'b1);
      wr(2'd2, 20'h00200, 32'hA5000030, 1'b1);
      wr(2'd0, 20'h0000C, 32'hA5000011, 1'b1);
      wr(2'd1, 20'h00104, 32'hA5000021, 1'b1);
      chk("t2_done_ch1", {61'd0, ch_load_done}, 64'h2);
      wr(2'd2, 20'hFFFFC, 32'hA5ABCDEF, 1'b1);
      wr(2'd0, 20'h00004, 32'hA5000012, 1'b1);
      wr(2'd2, 20'h00204, 32'hA5000032, 1'b1);
      chk("t2_done_ch12", {61'd0, ch_load_done}, 64'h6);
      chk("t2_cs_before_last", {63'd0, core_start}, 64'd0);
      wr(2'd0, 20'h00004, 32'hA5000013, 1'b1);
      chk("t2_done_all", {61'd0, ch_load_done}, 64'h7);
      chk("t2_cs_with_last", {63'd0, core_start}, 64'd0);
      cyc();
      chk("t2_core_start", {63'd0, core_start}, 64'd1);
      n_cs = 1;
      wr(2'd1, 20'h00000, 32'h00000099, 1'b0);
      if (core_start) n_cs++;
      for (int k = 0; k < 9; k++) begin
         cyc();
         if (core_start) n_cs++;
      end
      chk("t2_cs_pulses", 64'(n_cs), 64'd1);
      chk("t2_run_busy", {63'd0, ctrl_busy}, 64'd1);
      chk("t2_run_ready", {63'd0, ctrl_ready}, 64'd0);
      core_done = 1'b1;
      cyc();
      core_done = 1'b0;
      chk("t2_ready", {63'd0, ctrl_ready}, 64'd1);
      chk("t2_busy_off", {63'd0, ctrl_busy}, 64'd0);
      chk("t2_wrcnt", {32'd0, wr_count_dbg}, 64'd9);
      chk("t2_err", {61'd0, err_flags}, 64'd0);

      // Bad channel then misaligned address; neither counts.
      start_load(19'd4, 19'd2, 19'd3);
      chk("t3_ready_off", {63'd0, ctrl_ready}, 64'd0);
      chk("t3_wrcnt_clr", {32'd0, wr_count_dbg}, 64'd0);
      wr(2'd3, 20'h00000, 32'h00000055, 1'b0);
      chk("t3_err_ch", {61'd0, err_flags}, 64'h1);
      wr(2'd0, 20'h00006, 32'h00000066, 1'b0);
      chk("t3_err_align", {61'd0, err_flags}, 64'h3);
      chk("t3_wrcnt", {32'd0, wr_count_dbg}, 64'd0);
      chk("t3_done", {61'd0, ch_load_done}, 64'd0);
      wr(2'd0, 20'h00010, 32'h00000077, 1'b1);
      chk("t3_wrcnt_ok", {32'd0, wr_count_dbg}, 64'd1);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("t3_abort_busy", {63'd0, ctrl_busy}, 64'd0);
      chk("t3_abort_err", {61'd0, err_flags}, 64'h3);

      // Overflow on ch0 (len 2); load_start during LOAD is ignored.
      start_load(19'd2, 19'd1, 19'd1);
      chk("t4_err_clr", {61'd0, err_flags}, 64'd0);
      wr(2'd0, 20'h00000, 32'h12000001, 1'b1);
      chk("t4_done_1", {61'd0, ch_load_done}, 64'd0);
      load_start = 1'b1;
      wr(2'd0, 20'h00004, 32'h12000002, 1'b1);
      load_start = 1'b0;
      chk("t4_done_2nd", {61'd0, ch_load_done}, 64'h1);
      chk("t4_wrcnt", {32'd0, wr_count_dbg}, 64'd2);
      wr(2'd0, 20'h00008, 32'h12000003, 1'b0);
      chk("t4_err_ovf", {61'd0, err_flags}, 64'h4);
      chk("t4_wrcnt_ovf", {32'd0, wr_count_dbg}, 64'd2);
      wr(2'd1, 20'h00000, 32'h12000004, 1'b1);
      wr(2'd2, 20'h00000, 32'h12000005, 1'b1);
      chk("t4_done_all", {61'd0, ch_load_done}, 64'h7);
      cyc();
      chk("t4_core_start", {63'd0, core_start}, 64'd1);
      cyc();
      chk("t4_run_cs", {63'd0, core_start}, 64'd0);
      chk("t4_run_busy", {63'd0, ctrl_busy}, 64'd1);

      // Abort together with load_start in RUN: abort wins.
      abort      = 1'b1;
      load_start = 1'b1;
      cyc();
      abort      = 1'b0;
      load_start = 1'b0;
      chk("t6_busy", {63'd0, ctrl_busy}, 64'd0);
      chk("t6_ready", {63'd0, ctrl_ready}, 64'd0);
      chk("t6_done", {61'd0, ch_load_done}, 64'd0);
      chk("t6_err_kept", {61'd0, err_flags}, 64'h4);
      n_cs = 0;
      if (core_start) n_cs++;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (core_start) n_cs++;
      end
      chk("t6_cs_pulses", 64'(n_cs), 64'd0);
      core_done = 1'b1;
      cyc();
      core_done = 1'b0;
      chk("t6_core_done_idle", {63'd0, ctrl_ready}, 64'd0);

      // All lengths zero: load_start in cycle 1, LOAD in cycle 2, core_start in cycle 3.
      start_load(19'd0, 19'd0, 19'd0);
      chk("t5_done", {61'd0, ch_load_done}, 64'h7);
      chk("t5_busy", {63'd0, ctrl_busy}, 64'd1);
      chk("t5_cs_early", {63'd0, core_start}, 64'd0);
      chk("t5_err_clr", {61'd0, err_flags}, 64'd0);
      wr(2'd1, 20'h00000, 32'h00000042, 1'b0);
      chk("t5_core_start", {63'd0, core_start}, 64'd1);
      chk("t5_err_ovf", {61'd0, err_flags}, 64'h4);
      cyc();
      chk("t5_cs_end", {63'd0, core_start}, 64'd0);
      core_done = 1'b1;
      cyc();
      core_done = 1'b0;
      chk("t5_ready", {63'd0, ctrl_ready}, 64'd1);
      chk("t5_wrcnt", {32'd0, wr_count_dbg}, 64'd0);

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
